// File: rtl/reload_counter_pkg.sv
// Shared definitions for the reload_counter tick generator.
// Provides the run-state encoding and the count-direction constants.
package reload_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/reload_counter.sv
// Load/terminal-count counter with direction, auto-reload, abort and busy.
// Ports: clk, reset_n (sync, active-low), load, load_val, up, reload_en,
//        count_en, abort in; count, done (1-cycle terminal pulse), busy out.
module reload_counter
    import reload_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             reload_en,
    input  logic             count_en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy
);

    logic [WIDTH-1:0] target;
    logic             dir;
    logic             reload;
    state_t           state;

    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] target_n;
    logic             dir_n;
    logic             reload_n;
    state_t           state_n;
    logic             done_n;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] start;
    logic             at_term;

    assign term    = (dir == DIR_UP) ? target : '0;
    assign start   = (dir == DIR_UP) ? '0 : target;
    assign at_term = (count == term);

    always_comb begin
        count_n  = count;
        target_n = target;
        dir_n    = dir;
        reload_n = reload;
        state_n  = state;
        done_n   = 1'b0;

        if (abort) begin
            state_n = IDLE;
        end else if (load) begin
            target_n = load_val;
            dir_n    = up;
            reload_n = reload_en;
            count_n  = up ? '0 : load_val;
            state_n  = RUN;
            // Start equals terminal only for a zero-length run.
            done_n   = (load_val == '0);
        end else if (state == RUN) begin
            if (at_term && !reload) begin
                // Terminal already flagged; leave RUN without stepping.
                state_n = IDLE;
            end else if (count_en) begin
                if (at_term) begin
                    count_n = start;
                end else if (dir == DIR_UP) begin
                    count_n = count + WIDTH'(1);
                end else begin
                    count_n = count - WIDTH'(1);
                end
                done_n = (count_n == term);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            target <= '0;
            dir    <= DIR_DOWN;
            reload <= 1'b0;
            state  <= IDLE;
            done   <= 1'b0;
        end else begin
            count  <= count_n;
            target <= target_n;
            dir    <= dir_n;
            reload <= reload_n;
            state  <= state_n;
            done   <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_reload_counter.sv
// Directed testbench for reload_counter (WIDTH=8 and WIDTH=3 instances).
// Expected values are hand-derived; one summary line at the end.
module tb_reload_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic [7:0] load_val;
    logic       up;
    logic       reload_en;
    logic       count_en;
    logic       abort;
    logic [7:0] count;
    logic       done;
    logic       busy;
    logic [2:0] count3;
    logic       done3;
    logic       busy3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reload_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .up       (up),
        .reload_en(reload_en),
        .count_en (count_en),
        .abort    (abort),
        .count    (count),
        .done     (done),
        .busy     (busy)
    );

    reload_counter #(.WIDTH(3)) dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val[2:0]),
        .up       (up),
        .reload_en(reload_en),
        .count_en (count_en),
        .abort    (abort),
        .count    (count3),
        .done     (done3),
        .busy     (busy3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int d, input int b);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".done"},  int'(done),  d);
        chk({tag, ".busy"},  int'(busy),  b);
    endtask

    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        load_val  = 8'd0;
        up        = 1'b0;
        reload_en = 1'b0;
        count_en  = 1'b0;
        abort     = 1'b0;

        // Reset state
        step();
        chk_out("reset", 0, 0, 0);
        reset_n = 1'b1;
        step();
        chk_out("idle", 0, 0, 0);

        // Load 7 down, count_en held high
        load = 1'b1; load_val = 8'd7; up = 1'b0; reload_en = 1'b0;
        count_en = 1'b1;
        step();
        load = 1'b0;
        chk_out("dn7.load", 7, 0, 1);
        chk("dn7.w3count", int'(count3), 7);
        for (int k = 6; k >= 0; k--) begin
            step();
            chk_out("dn7.run", k, (k == 0) ? 1 : 0, 1);
            chk("dn7.w3count", int'(count3), k);
            chk("dn7.w3done", int'(done3), (k == 0) ? 1 : 0);
        end
        step();
        chk_out("dn7.end", 0, 0, 0);
        chk("dn7.w3busy", int'(busy3), 0);

        // Load 5 up with reload
        load = 1'b1; load_val = 8'd5; up = 1'b1; reload_en = 1'b1;
        step();
        load = 1'b0;
        chk_out("up5.load", 0, 0, 1);
        for (int i = 1; i <= 13; i++) begin
            step();
            chk_out("up5.run", i % 6, (i % 6 == 5) ? 1 : 0, 1);
        end

        // Down from 3 with gated count_en
        load = 1'b1; load_val = 8'd3; up = 1'b0; reload_en = 1'b0;
        count_en = 1'b0;
        step();
        load = 1'b0;
        chk_out("gate.load", 3, 0, 1);
        count_en = 1'b1; step(); chk_out("gate.e1", 2, 0, 1);
        count_en = 1'b0; step(); chk_out("gate.h1", 2, 0, 1);
        count_en = 1'b1; step(); chk_out("gate.e2", 1, 0, 1);
        count_en = 1'b0; step(); chk_out("gate.h2", 1, 0, 1);
        count_en = 1'b1; step(); chk_out("gate.e3", 0, 1, 1);
        count_en = 1'b0; step(); chk_out("gate.end", 0, 0, 0);

        // Load 0 without reload
        load = 1'b1; load_val = 8'd0; up = 1'b0; reload_en = 1'b0;
        step();
        load = 1'b0;
        chk_out("z.load", 0, 1, 1);
        step();
        chk_out("z.end", 0, 0, 0);

        // Load 0 with reload
        load = 1'b1; reload_en = 1'b1; count_en = 1'b1;
        step();
        load = 1'b0;
        chk_out("zr.load", 0, 1, 1);
        step(); chk_out("zr.r1", 0, 1, 1);
        step(); chk_out("zr.r2", 0, 1, 1);
        count_en = 1'b0;
        step(); chk_out("zr.hold", 0, 0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("zr.abort", 0, 0, 0);

        // Abort beats load at count 4 of a down run from 9
        load = 1'b1; load_val = 8'd9; up = 1'b0; reload_en = 1'b0;
        count_en = 1'b1;
        step();
        load = 1'b0;
        chk_out("ab.load", 9, 0, 1);
        for (int k = 8; k >= 4; k--) begin
            step();
            chk_out("ab.run", k, 0, 1);
        end
        abort = 1'b1; load = 1'b1; load_val = 8'd2;
        step();
        abort = 1'b0; load = 1'b0;
        chk_out("ab.hit", 4, 0, 0);
        step();
        chk_out("ab.idle", 4, 0, 0);
        load = 1'b1; load_val = 8'd2;
        step();
        load = 1'b0;
        chk_out("ab.l2", 2, 0, 1);
        step(); chk_out("ab.r1", 1, 0, 1);
        step(); chk_out("ab.r0", 0, 1, 1);
        step(); chk_out("ab.end", 0, 0, 0);

        // Reset mid-run with load high
        load = 1'b1; load_val = 8'd6; up = 1'b1; reload_en = 1'b0;
        step();
        load = 1'b0;
        chk_out("rs.load", 0, 0, 1);
        step(); chk_out("rs.r1", 1, 0, 1);
        step(); chk_out("rs.r2", 2, 0, 1);
        reset_n = 1'b0; load = 1'b1; load_val = 8'd3;
        step();
        chk_out("rs.hit", 0, 0, 0);
        reset_n = 1'b1; load = 1'b0;
        step();
        chk_out("rs.after", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reload_counter.md
# reload_counter

Parametrised load/terminal-count counter, the general successor to the 3-bit down counter. It adds configurable width, up or down direction, auto-reload for periodic operation, abort, and a busy flag. It serves as the shared timing/tick generator for datapath blocks that need "count N enabled cycles, then flag".

## Interface
Parameters:
- WIDTH, 8, counter and load-value width (≥2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- load  in  1  latch load_val/up/reload_en, start run
- load_val  in  WIDTH  run length N (target)
- up  in  1  direction, sampled at load: 1 = count 0→N, 0 = count N→0
- reload_en  in  1  auto-reload mode, sampled at load
- count_en  in  1  step enable; ignored when not busy
- abort  in  1  stop run immediately, hold count
- count  out  WIDTH  current count (registered)
- done  out  1  one-cycle terminal pulse (registered)
- busy  out  1  1 while in RUN

## Operation
- Internal registers: count, target, dir, reload, state ∈ {IDLE, RUN}.
- Terminal value T = target when dir=up, else 0. Start value S = 0 when dir=up, else target.
- Priority per edge: reset_n=0 > abort > load > count_en.
- Reset: count=0, target=0, dir=down, reload=0, state=IDLE, done=0, busy=0.
- Abort: state←IDLE, count holds, done←0. Latched config is kept.
- Load (any state): target←load_val, dir←up, reload←reload_en, count←S, state←RUN.
- RUN, count_en=1, count≠T: count steps ±1 toward T.
- RUN, count_en=1, count=T, reload=1: count←S and stay in RUN.
- RUN, count=T, reload=0: state←IDLE on the next edge regardless of count_en; count holds T.
- RUN, count_en=0: hold everything.
- IDLE: count holds; count_en is ignored.
- done=1 exactly in cycles where the preceding edge wrote T into count via load, step, or reload. It is never high for two cycles, except when N=0 with reload, where it stays high each enabled cycle.
- N=0: load gives count=0=T and done=1 on the next cycle. Without reload the block then returns to IDLE.
- Count never wraps: it is bounded in [0, target]. No modular arithmetic is required.
- Loading while busy restarts cleanly. Any pending terminal is discarded.

## Timing
- Load→count visible: 1 cycle.
- Continuous count_en, load N at edge 0: count=T after edge N, done high in the cycle after edge N.
- Reload period: N+1 enabled cycles between done pulses.
- busy falls 1 cycle after done when reload=0.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package reload_counter_pkg: state enum (IDLE, RUN) and DIR_UP/DIR_DOWN constants.
- Single module, no sub-module. Next-state/next-count logic in one combinational block; one registered block.

## Test plan
- WIDTH=3, load 7 down, count_en held high → count 7,6,…,0; done one cycle at count 0; busy drops the next cycle.
- WIDTH=8, load 5 up with reload → count 0..5,0..5…; done every 6 cycles while count_en=1.
- count_en toggled 1/0 during a down run from 3 → count holds on 0-cycles; done arrives after exactly 3 enabled steps.
- Load 0 with and without reload → done the next cycle; without reload busy=0 after 2 cycles, with reload done stays high.
- Abort at count=4 of a down run from 9; load asserted the same cycle → abort wins, count stays 4, busy=0, no done. A later load of 2 runs normally.
- reset_n low mid-run with load high → count=0, done=0, busy=0 after the edge. A load in the same cycle is ignored.
